// File: rtl/subpel_pkg.sv
// Shared constants, types and the column packing helper for the sub-pel row server.
package subpel_pkg;

    localparam int PIX_W   = 8;
    localparam int BLK     = 15;
    localparam int ROW_W   = PIX_W * BLK;
    localparam int BLK_PIX = BLK * BLK;
    localparam int IDX_W   = $clog2(BLK);
    localparam int LANE_W  = $clog2(ROW_W);
    localparam int FILL_W  = $clog2(BLK_PIX);

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [FILL_W-1:0] fill_t;

    // Bit position of the byte lane holding column col (column 0 sits at the LSB).
    function automatic lane_t lane_lsb(input idx_t col);
        return lane_t'(col) * lane_t'(PIX_W);
    endfunction

endpackage

// File: rtl/subpel_row_server_if.sv
// Pixel-stream and row-request signals between a pixel source / interpolator and the row server.
interface subpel_row_server_if;
    import subpel_pkg::*;

    pix_t        pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [63:0] next_row;
    row_t        in_row;
    logic        blk_valid;
    logic        blk_done;
    fill_t       fill_level;

    modport master (
        output pix_in, pix_valid, next_row, blk_done,
        input  pix_ready, in_row, blk_valid, fill_level
    );

    modport slave (
        input  pix_in, pix_valid, next_row, blk_done,
        output pix_ready, in_row, blk_valid, fill_level
    );

endinterface

// File: rtl/subpel_row_bank.sv
// One block buffer: BLK rows of packed pixels, single-pixel write port, combinational row read.
module subpel_row_bank
    import subpel_pkg::*;
(
    input  logic clk,
    input  logic we,
    input  idx_t wr_row,
    input  idx_t wr_col,
    input  pix_t wr_data,
    input  idx_t rd_row,
    output row_t rd_data
);

    row_t mem [BLK];

    // Storage is deliberately not reset; full flags in the top qualify its contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][lane_lsb(wr_col) +: PIX_W] <= wr_data;
        end
    end

    // Out-of-range rows are gated to zero by the top, so no guard is needed here.
    assign rd_data = mem[rd_row];

endmodule

// File: rtl/subpel_row_server.sv
// Ping-pong block loader: packs a raster pixel stream into two banks and serves
// whole rows of the completed bank to the interpolator by row index.
module subpel_row_server #(
    parameter int PIX_W = 8,
    parameter int BLK   = 15,
    parameter int ROW_W = PIX_W * BLK
) (
    input logic               clk,
    input logic               rst,
    subpel_row_server_if.slave bus
);

    localparam int IDX_W = $clog2(BLK);
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t        LAST_IDX  = idx_t'(BLK - 1);
    localparam logic [63:0] ROW_LIMIT = 64'(BLK);

    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [7:0] wr_cnt;
    idx_t       wr_row;
    idx_t       wr_col;

    logic       accept;
    logic       last_pix;
    logic       blk_release;
    logic [1:0] full_set;
    logic [1:0] full_clr;
    logic [ROW_W-1:0] rd_data [2];

    assign bus.pix_ready  = !full[wr_bank];
    assign accept         = bus.pix_valid && bus.pix_ready;
    assign last_pix       = (wr_row == LAST_IDX) && (wr_col == LAST_IDX);
    assign bus.blk_valid  = full[rd_bank];
    assign blk_release    = bus.blk_done && full[rd_bank];
    assign bus.fill_level = wr_cnt;

    // A completing write and a release always target different banks, so set and clear never collide.
    assign full_set = {accept && last_pix && wr_bank, accept && last_pix && !wr_bank};
    assign full_clr = {blk_release && rd_bank, blk_release && !rd_bank};

    // Write pointer walk, bank flags and bank selection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
        end else begin
            full <= (full & ~full_clr) | full_set;
            if (blk_release) begin
                rd_bank <= ~rd_bank;
            end
            if (accept) begin
                if (last_pix) begin
                    wr_bank <= ~wr_bank;
                    wr_cnt  <= '0;
                    wr_row  <= '0;
                    wr_col  <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 8'd1;
                    if (wr_col == LAST_IDX) begin
                        wr_col <= '0;
                        wr_row <= wr_row + idx_t'(1);
                    end else begin
                        wr_col <= wr_col + idx_t'(1);
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        subpel_row_bank u_bank (
            .clk     (clk),
            .we      (accept && (wr_bank == 1'(b))),
            .wr_row  (wr_row),
            .wr_col  (wr_col),
            .wr_data (bus.pix_in),
            .rd_row  (bus.next_row[IDX_W-1:0]),
            .rd_data (rd_data[b])
        );
    end

    assign bus.in_row = (bus.blk_valid && (bus.next_row < ROW_LIMIT)) ? rd_data[rd_bank] : '0;

endmodule
